// File: rtl/fft_stage_seq.sv
// Sequencer for a pipelined radix-2 DIF FFT: drives per-stage butterfly selects, twiddle addresses and output framing.
// Define FFT_SEQ_BITREV_EN to report out_idx as the bit-reversed (natural-order bin) output counter.
module fft_stage_seq #(
  parameter int LOG2N   = 6,
  parameter int STG_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         ce,
  output logic [LOG2N-1:0]             bf_en,
  output logic [LOG2N*(LOG2N-1)-1:0]   tw_addr,
  output logic                         out_valid,
  output logic                         out_last,
  output logic [LOG2N-1:0]             out_idx,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         ovf_err
);

  localparam int N  = 1 << LOG2N;
  localparam int TW = LOG2N - 1;
  localparam int LT = (N - 1) + LOG2N * STG_LAT;
  localparam int CW = $clog2(LT + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  // Number of ce cycles before stage s starts consuming data.
  function automatic int stageOff(input int s);
    int acc;
    acc = 0;
    for (int j = 0; j < s; j++) acc += (N >> (j + 1)) + STG_LAT;
    return acc;
  endfunction

`ifdef FFT_SEQ_BITREV_EN
  function automatic logic [LOG2N-1:0] bitRev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction
`endif

  state_t                  stateQ;
  logic [CW-1:0]           cntQ;
  logic [CW-1:0]           drainQ;
  logic [LOG2N-1:0]        outCntQ;
  logic [LOG2N-1:0]        kQ [LOG2N];

  logic                    ceD;
  logic                    outValidD;
  logic [LOG2N-1:0]        activeD;
  logic [LOG2N-1:0]        bfEnD;
  logic [LOG2N*TW-1:0]     twAddrD;
  logic [LOG2N-1:0]        outIdxD;

  // The cntQ/kQ values seen here belong to the cycle being processed; they advance after it.
  always_comb begin
    ceD     = 1'b0;
    activeD = '0;
    bfEnD   = '0;
    twAddrD = '0;
    unique case (stateQ)
      RUN:     ceD = in_valid;
      FLUSH:   ceD = 1'b1;
      default: ceD = 1'b0;
    endcase
    for (int s = 0; s < LOG2N; s++) begin
      activeD[s] = (stateQ != IDLE) && (int'(cntQ) >= stageOff(s));
      if (activeD[s]) begin
        bfEnD[s] = kQ[s][LOG2N-1-s];
        twAddrD[s*TW +: TW] = TW'((kQ[s] & LOG2N'((N >> (s + 1)) - 1)) << s);
      end
    end
    outValidD = ceD && (cntQ == CW'(LT));
`ifdef FFT_SEQ_BITREV_EN
    outIdxD = bitRev(outCntQ);
`else
    outIdxD = outCntQ;
`endif
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      stateQ     <= IDLE;
      cntQ       <= '0;
      drainQ     <= '0;
      outCntQ    <= '0;
      for (int s = 0; s < LOG2N; s++) kQ[s] <= '0;
      ce         <= 1'b0;
      bf_en      <= '0;
      tw_addr    <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_idx    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      ce         <= ceD;
      bf_en      <= bfEnD;
      tw_addr    <= twAddrD;
      out_valid  <= outValidD;
      out_last   <= outValidD && (outCntQ == LOG2N'(N - 1));
      out_idx    <= outValidD ? outIdxD : '0;
      frame_done <= 1'b0;

      // cntQ saturates at LT: every stage offset is below it, so no further counting matters.
      if (ceD && (cntQ != CW'(LT))) cntQ <= cntQ + 1'b1;
      if (outValidD) outCntQ <= outCntQ + 1'b1;
      for (int s = 0; s < LOG2N; s++) begin
        if (stateQ == IDLE) kQ[s] <= '0;
        else if (ceD && activeD[s]) kQ[s] <= kQ[s] + 1'b1;
      end

      unique case (stateQ)
        IDLE: begin
          cntQ    <= '0;
          outCntQ <= '0;
          busy    <= start;
          if (start) begin
            stateQ  <= RUN;
            ovf_err <= in_valid;
          end else if (in_valid) begin
            ovf_err <= 1'b1;
          end
        end
        RUN: begin
          busy <= 1'b1;
          if (in_valid && in_last) begin
            stateQ <= FLUSH;
            drainQ <= '0;
            if (kQ[0] != LOG2N'(N - 1)) ovf_err <= 1'b1;
          end
        end
        FLUSH: begin
          if (in_valid) ovf_err <= 1'b1;
          if (drainQ == CW'(LT - 1)) begin
            stateQ     <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            drainQ <= drainQ + 1'b1;
            busy   <= 1'b1;
          end
        end
        default: begin
          stateQ <= IDLE;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stage_seq.sv
// Self-checking bench for fft_stage_seq: directed scenarios plus random runs against an index-arithmetic model.
// Build with FFT_SEQ_BITREV_EN defined to check the bit-reversed out_idx ordering.
module tb_fft_stage_seq;

  localparam int LOG2N = 6;
  localparam int N     = 64;
  localparam int TW    = LOG2N - 1;
  localparam int LT    = 69;

  logic                      clk = 1'b0;
  logic                      rstn = 1'b1;
  logic                      start = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_last = 1'b0;
  logic                      ce;
  logic [LOG2N-1:0]          bf_en;
  logic [LOG2N*TW-1:0]       tw_addr;
  logic                      out_valid;
  logic                      out_last;
  logic [LOG2N-1:0]          out_idx;
  logic                      busy;
  logic                      frame_done;
  logic                      ovf_err;

  fft_stage_seq #(.LOG2N(LOG2N), .STG_LAT(1)) dut (
    .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_last(in_last),
    .ce(ce), .bf_en(bf_en), .tw_addr(tw_addr), .out_valid(out_valid), .out_last(out_last),
    .out_idx(out_idx), .busy(busy), .frame_done(frame_done), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycleNo = 0;

  // Reference model state: run phase, ce cycles since run start, flush cycles, sticky error
  int  mState = 0;
  int  mCe = 0;
  int  mFlush = 0;
  bit  mOvf = 1'b0;
  int  stageL [LOG2N];

  int unsigned expCe, expBf, expTw, expOv, expOl, expIdx, expBusy, expFd, expOvf;

  int nOut, nLast, nDone, nCoinc, runLen, maxRun, firstCe, firstOut;

  task automatic checkOutput(input string tag, input int unsigned observed, input int unsigned expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cycleNo, observed, expected);
    end
  endtask

  function automatic int unsigned revBits(input int unsigned x);
    int unsigned r;
    r = 0;
    for (int i = 0; i < LOG2N; i++) if (x[i]) r |= (1 << (LOG2N - 1 - i));
    return r;
  endfunction

  // Expected outputs follow directly from the ce count: stage s has seen (c - L_s) samples.
  task automatic modelStep(input bit st, input bit v, input bit l, input bit r);
    bit ceNow;
    int ks, oi;
    expCe = 0; expBf = 0; expTw = 0; expOv = 0; expOl = 0; expIdx = 0; expFd = 0;
    if (r) begin
      mState = 0; mCe = 0; mFlush = 0; mOvf = 1'b0;
      expBusy = 0; expOvf = 0;
      return;
    end
    ceNow = (mState == 1 && v) || (mState == 2);
    expCe = ceNow;
    for (int s = 0; s < LOG2N; s++) begin
      if (mState != 0 && mCe >= stageL[s]) begin
        ks = (mCe - stageL[s]) % N;
        expBf |= ((ks >> (LOG2N - 1 - s)) & 1) << s;
        expTw |= (((ks % (N >> (s + 1))) << s) % (1 << TW)) << (s * TW);
      end
    end
    if (ceNow && mCe >= LT) begin
      oi = (mCe - LT) % N;
      expOv = 1;
      expOl = (oi == N - 1);
`ifdef FFT_SEQ_BITREV_EN
      expIdx = revBits(oi);
`else
      expIdx = oi;
`endif
    end
    case (mState)
      0: if (st) begin mState = 1; mCe = 0; mOvf = v; end
         else if (v) mOvf = 1'b1;
      1: if (v && l) begin
           if (mCe % N != N - 1) mOvf = 1'b1;
           mState = 2; mFlush = 0;
         end
      default: begin
        if (v) mOvf = 1'b1;
        mFlush++;
        if (mFlush == LT) begin expFd = 1; mState = 0; end
      end
    endcase
    if (ceNow) mCe++;
    expBusy = (mState != 0);
    expOvf = mOvf;
  endtask

  task automatic applyStimulus(input bit st, input bit v, input bit l, input bit r);
    start = st; in_valid = v; in_last = l; rstn = r;
    modelStep(st, v, l, r);
    @(posedge clk);
    #1;
    cycleNo++;
    checkOutput("ce", ce, expCe);
    checkOutput("bf_en", bf_en, expBf);
    checkOutput("tw_addr", tw_addr, expTw);
    checkOutput("out_valid", out_valid, expOv);
    checkOutput("out_last", out_last, expOl);
    checkOutput("out_idx", out_idx, expIdx);
    checkOutput("busy", busy, expBusy);
    checkOutput("frame_done", frame_done, expFd);
    checkOutput("ovf_err", ovf_err, expOvf);
    if (ce && firstCe < 0) firstCe = cycleNo;
    if (out_valid && firstOut < 0) firstOut = cycleNo;
    if (out_valid) begin nOut++; runLen++; if (runLen > maxRun) maxRun = runLen; end
    else runLen = 0;
    if (out_last) nLast++;
    if (frame_done) nDone++;
    if (frame_done && out_last) nCoinc++;
  endtask

  task automatic clearStats();
    nOut = 0; nLast = 0; nDone = 0; nCoinc = 0; runLen = 0; maxRun = 0; firstCe = -1; firstOut = -1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Feeds 'total' samples; gapMode 1 alternates valid/idle, 2 is random gaps.
  task automatic feedRun(input int total, input int gapMode);
    int acc;
    bit v;
    acc = 0;
    while (acc < total) begin
      if (gapMode == 1) v = (cycleNo % 2 == 0);
      else if (gapMode == 2) v = ($urandom_range(0, 3) != 0);
      else v = 1'b1;
      applyStimulus(gapMode == 2 ? 1'($urandom_range(0, 1)) : 1'b0, v,
                    v ? (acc == total - 1) : (gapMode == 2 ? 1'($urandom_range(0, 1)) : 1'b0), 1'b0);
      if (v) acc++;
    end
  endtask

  initial begin
    stageL[0] = 0;
    for (int s = 1; s < LOG2N; s++) stageL[s] = stageL[s-1] + (N >> s) + 1;

    clearStats();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    idleCycles(3);

    $display("[TB] single frame");
    clearStats();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    feedRun(64, 0);
    idleCycles(LT + 4);
    checkOutput("latency", firstOut - firstCe, LT);
    checkOutput("single_outputs", nOut, 64);
    checkOutput("single_done", nDone, 1);
    checkOutput("single_done_with_last", nCoinc, 1);

    $display("[TB] gapped frame");
    clearStats();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    feedRun(64, 1);
    idleCycles(LT + 4);
    checkOutput("gap_outputs", nOut, 64);
    checkOutput("gap_done", nDone, 1);

    $display("[TB] back-to-back frames");
    clearStats();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    feedRun(128, 0);
    idleCycles(LT + 4);
    checkOutput("b2b_contiguous", maxRun, 128);
    checkOutput("b2b_lasts", nLast, 2);
    checkOutput("b2b_done", nDone, 1);

    $display("[TB] protocol errors");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idleCycles(3);
    checkOutput("idle_valid_sticky", ovf_err, 1);
    clearStats();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("start_clears_ovf", ovf_err, 0);
    feedRun(41, 0);
    checkOutput("trunc_ovf", ovf_err, 1);
    idleCycles(LT + 4);
    checkOutput("trunc_done", nDone, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("start_with_valid_ovf", ovf_err, 1);
    feedRun(64, 0);
    idleCycles(LT + 4);

    $display("[TB] reset mid-run");
    clearStats();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    feedRun(30, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    idleCycles(LT + 4);
    checkOutput("reset_no_done", nDone, 0);

    $display("[TB] random runs");
    for (int r = 0; r < 8; r++) begin
      int total;
      total = $urandom_range(1, 2) * 64;
      if ($urandom_range(0, 3) == 0) total = $urandom_range(1, total - 1);
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      feedRun(total, 2);
      for (int i = 0; i < LT + 6; i++)
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0), 1'b0, 1'b0);
      idleCycles($urandom_range(1, 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
